// File: rtl/keypad_event_encoder_pkg.sv
// Shared constants for the keypad event encoder: FSM encoding, default idle code
// and the key-count thresholds of the multi-key policy.
package keypad_event_encoder_pkg;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_PRESS_DB = 2'd1;
   localparam logic [1:0] ST_HELD     = 2'd2;
   localparam logic [1:0] ST_REL_DB   = 2'd3;

   localparam logic [3:0] NO_KEY_CODE_DEF = 4'hE;

   // Number of simultaneously pressed keys that selects each policy branch.
   localparam int POLICY_SINGLE = 1;
   localparam int POLICY_PAIR   = 2;
   localparam int POLICY_MANY   = 3;

endpackage

// File: rtl/keypad_policy_resolver.sv
// Combinational multi-key policy: one key -> its index, two keys -> higher index,
// three or more -> lowest index, none -> no candidate.
module keypad_policy_resolver
   import keypad_event_encoder_pkg::*;
#(
   parameter int N_KEYS = 12,
   parameter int CODE_W = 4
) (
   input  logic [N_KEYS-1:0] ksync,
   output logic [CODE_W-1:0] cand_code,
   output logic              cand_valid
);

   localparam int CW = $clog2(N_KEYS + 1);

   logic [CW-1:0]     n_set;
   logic [CODE_W-1:0] lo_idx;
   logic [CODE_W-1:0] hi_idx;
   logic              found;

   always_comb begin
      n_set  = '0;
      lo_idx = '0;
      hi_idx = '0;
      found  = 1'b0;
      for (int i = 0; i < N_KEYS; i++) begin
         if (ksync[i]) begin
            n_set  = n_set + CW'(1);
            hi_idx = CODE_W'(i);
            if (!found) begin
               lo_idx = CODE_W'(i);
               found  = 1'b1;
            end
         end
      end
   end

   always_comb begin
      cand_valid = (n_set >= CW'(POLICY_SINGLE));
      if (n_set >= CW'(POLICY_MANY))
         cand_code = lo_idx;
      else if (n_set == CW'(POLICY_PAIR))
         cand_code = hi_idx;
      else
         cand_code = lo_idx;
   end

endmodule

// File: rtl/keypad_event_encoder.sv
// Synchronises and debounces the keypad, applies the multi-key policy and queues
// one code per press (plus optional auto-repeat) into a valid/ready event FIFO.
module keypad_event_encoder
   import keypad_event_encoder_pkg::*;
#(
   parameter int                N_KEYS          = 12,
   parameter int                CODE_W          = 4,
   parameter logic [CODE_W-1:0] NO_KEY_CODE     = CODE_W'(NO_KEY_CODE_DEF),
   parameter int                DEBOUNCE_CYCLES = 1000,
   parameter int                REPEAT_EN       = 0,
   parameter int                REPEAT_DELAY    = 50000,
   parameter int                REPEAT_PERIOD   = 10000,
   parameter int                FIFO_DEPTH      = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] key,
   output logic [CODE_W-1:0] code_out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              key_held,
   output logic              overflow
);

   localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);
   localparam int AW      = $clog2(FIFO_DEPTH);

   // "Last" values: the counter reaches its terminal value on the increment taken
   // in the cycle where it already holds terminal-1.
   localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] PER_LAST   = RPT_W'(REPEAT_PERIOD - 1);

   logic [N_KEYS-1:0] ksync_meta;
   logic [N_KEYS-1:0] ksync;
   logic [CODE_W-1:0] cand_code;
   logic              cand_valid;

   logic [1:0]        state;
   logic [CODE_W-1:0] lat_code;
   logic [CNT_W-1:0]  cnt;
   logic [RPT_W-1:0]  rpt_cnt;
   logic              rpt_first;

   logic              db_hit;
   logic              rpt_hit;
   logic              push;

   logic [CODE_W-1:0] mem [FIFO_DEPTH];
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic              fifo_empty;
   logic              fifo_full;
   logic              pop;
   logic              push_accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ksync_meta <= '0;
         ksync      <= '0;
      end else begin
         ksync_meta <= key;
         ksync      <= ksync_meta;
      end
   end

   keypad_policy_resolver #(
      .N_KEYS (N_KEYS),
      .CODE_W (CODE_W)
   ) u_policy (
      .ksync      (ksync),
      .cand_code  (cand_code),
      .cand_valid (cand_valid)
   );

   always_comb begin
      db_hit  = 1'b0;
      rpt_hit = 1'b0;
      if (state == ST_PRESS_DB && cand_valid && cand_code == lat_code && cnt >= DB_LAST)
         db_hit = 1'b1;
      if (REPEAT_EN != 0 && state == ST_HELD && cand_valid)
         rpt_hit = rpt_first ? (rpt_cnt >= DELAY_LAST) : (rpt_cnt >= PER_LAST);
      push = db_hit || rpt_hit;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         lat_code  <= '0;
         cnt       <= '0;
         rpt_cnt   <= '0;
         rpt_first <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cand_valid) begin
                  state    <= ST_PRESS_DB;
                  lat_code <= cand_code;
                  cnt      <= CNT_W'(1);
               end
            end
            ST_PRESS_DB: begin
               if (!cand_valid) begin
                  state <= ST_IDLE;
               end else if (cand_code != lat_code) begin
                  lat_code <= cand_code;
                  cnt      <= CNT_W'(1);
               end else if (db_hit) begin
                  state     <= ST_HELD;
                  rpt_cnt   <= '0;
                  rpt_first <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_HELD: begin
               // A different code while still held is deliberately ignored.
               if (!cand_valid) begin
                  state <= ST_REL_DB;
                  cnt   <= CNT_W'(1);
               end else if (rpt_hit) begin
                  rpt_cnt   <= '0;
                  rpt_first <= 1'b0;
               end else if (REPEAT_EN != 0) begin
                  rpt_cnt <= rpt_cnt + RPT_W'(1);
               end
            end
            default: begin
               // Release debounce; a re-press resumes the hold with repeat timing intact.
               if (cand_valid) begin
                  state <= ST_HELD;
                  cnt   <= '0;
               end else if (cnt >= DB_LAST) begin
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
         endcase
      end
   end

   assign key_held = (state == ST_HELD) || (state == ST_REL_DB);

   assign fifo_empty  = (wr_ptr == rd_ptr);
   assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop         = out_valid && out_ready;
   // When full, a simultaneous pop frees the head slot, which is exactly the write slot.
   assign push_accept = push && (!fifo_full || pop);

   always_ff @(posedge clk) begin
      if (push_accept)
         mem[wr_ptr[AW-1:0]] <= lat_code;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_accept)
            wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)
            rd_ptr <= rd_ptr + (AW+1)'(1);
         overflow <= push && fifo_full && !pop;
      end
   end

   // Head outputs depend only on FIFO state flops, never on this cycle's inputs.
   assign out_valid = !fifo_empty;
   assign code_out  = fifo_empty ? NO_KEY_CODE : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_keypad_event_encoder.sv
// Directed bench for keypad_event_encoder: expected codes are queued when a press
// is driven and checked in order as the consumer accepts them.
module tb_keypad_event_encoder;

   logic        clk;
   logic        rst;
   logic [11:0] key;
   logic [3:0]  code_out;
   logic        out_valid;
   logic        out_ready;
   logic        key_held;
   logic        overflow;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          evt_cnt = 0;
   int          ovf_cnt = 0;
   logic [3:0]  exp_q[$];
   int          evt_t[$];

   keypad_event_encoder #(
      .N_KEYS          (12),
      .CODE_W          (4),
      .NO_KEY_CODE     (4'hE),
      .DEBOUNCE_CYCLES (4),
      .REPEAT_EN       (1),
      .REPEAT_DELAY    (20),
      .REPEAT_PERIOD   (8),
      .FIFO_DEPTH      (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key       (key),
      .code_out  (code_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .key_held  (key_held),
      .overflow  (overflow)
   );

   // Clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input logic [11:0] mask, input int hold, input int rel);
      key = mask;
      step(hold);
      key = '0;
      step(rel);
   endtask

   // Scoreboard: every accepted event must match the oldest expected code.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL sb_unexpected: observed code %0d expected no event", code_out);
         end
         if (exp_q.size() != 0) check("sb_code", code_out, exp_q.pop_front());
         evt_t.push_back(cyc);
         evt_cnt++;
      end
      if (!rst && overflow) ovf_cnt++;
   end

   initial begin
      int  t0;
      int  e0;
      int  o0;
      int  n;
      int  rpt_off [5] = '{0, 20, 28, 36, 44};
      bit  bounce [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

      rst       = 1'b1;
      key       = '0;
      out_ready = 1'b1;
      step(3);
      check("rst_code", code_out, 4'hE);
      check("rst_valid", out_valid, 1'b0);
      check("rst_held", key_held, 1'b0);
      check("rst_ovf", overflow, 1'b0);
      rst = 1'b0;
      step(3);

      // Single clean press
      e0 = evt_cnt;
      t0 = cyc;
      exp_q.push_back(4'd5);
      key = 12'b1 << 5;
      step(10);
      check("single_held", key_held, 1'b1);
      key = '0;
      step(12);
      check("single_count", evt_cnt - e0, 1);
      if (evt_t.size() > e0) check("single_latency", evt_t[e0] - t0, 6);
      check("single_released", key_held, 1'b0);

      // Bouncing press: only the final 4-cycle stable run counts
      e0 = evt_cnt;
      t0 = cyc;
      exp_q.push_back(4'd5);
      for (int i = 0; i < 7; i++) begin
         key = bounce[i] ? (12'b1 << 5) : 12'b0;
         step(1);
      end
      step(6);
      key = '0;
      step(12);
      check("bounce_count", evt_cnt - e0, 1);
      if (evt_t.size() > e0) check("bounce_latency", evt_t[e0] - t0, 3 + 6);

      // Multi-key policy
      e0 = evt_cnt;
      exp_q.push_back(4'd9);
      press((12'b1 << 3) | (12'b1 << 9), 10, 12);
      check("pair_count", evt_cnt - e0, 1);
      e0 = evt_cnt;
      exp_q.push_back(4'd2);
      press((12'b1 << 2) | (12'b1 << 7) | (12'b1 << 11), 10, 12);
      check("many_count", evt_cnt - e0, 1);
      check("nokey_valid", out_valid, 1'b0);
      check("nokey_code", code_out, 4'hE);

      // Auto-repeat, then a short release glitch before the real release
      e0 = evt_cnt;
      t0 = cyc;
      repeat (5) exp_q.push_back(4'd0);
      key = 12'b1;
      step(52);
      key = '0;
      step(2);
      key = 12'b1;
      step(1);
      key = '0;
      step(30);
      check("rpt_count", evt_cnt - e0, 5);
      if (evt_t.size() >= e0 + 5) begin
         check("rpt_first_latency", evt_t[e0] - t0, 6);
         for (int i = 1; i < 5; i++) check("rpt_offset", evt_t[e0 + i] - evt_t[e0], rpt_off[i]);
      end
      check("rpt_released", key_held, 1'b0);

      // Overflow: six presses with the consumer stalled
      out_ready = 1'b0;
      o0 = ovf_cnt;
      exp_q.push_back(4'd1);
      exp_q.push_back(4'd6);
      exp_q.push_back(4'd8);
      exp_q.push_back(4'd10);
      press(12'b1 << 1, 8, 10);
      press(12'b1 << 6, 8, 10);
      press(12'b1 << 8, 8, 10);
      press(12'b1 << 10, 8, 10);
      press(12'b1 << 3, 8, 10);
      press(12'b1 << 7, 8, 10);
      check("ovf_pulses", ovf_cnt - o0, 2);
      check("full_valid", out_valid, 1'b1);
      check("full_head", code_out, 4'd1);

      // Push lands in the same cycle as a single pop while full
      exp_q.push_back(4'd11);
      key = 12'b1 << 11;
      step(5);
      out_ready = 1'b1;
      step(1);
      out_ready = 1'b0;
      key = '0;
      step(10);
      check("full_pushpop_ovf", ovf_cnt - o0, 2);
      check("full_pushpop_head", code_out, 4'd6);
      out_ready = 1'b1;
      step(10);
      check("drain_sb_empty", exp_q.size(), 0);
      check("drain_valid", out_valid, 1'b0);
      check("drain_code", code_out, 4'hE);

      // Reset in the middle of a press debounce
      e0 = evt_cnt;
      key = 12'b1 << 4;
      step(3);
      rst = 1'b1;
      #2;
      check("midrst_code", code_out, 4'hE);
      check("midrst_valid", out_valid, 1'b0);
      check("midrst_held", key_held, 1'b0);
      check("midrst_ovf", overflow, 1'b0);
      step(3);
      exp_q.push_back(4'd4);
      rst = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (out_valid) break;
      end
      check("midrst_latency", n, 6);
      @(posedge clk);
      #1;
      key = '0;
      step(12);
      check("midrst_count", evt_cnt - e0, 1);
      check("final_sb_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
